// File: rtl/drc_pkg.sv
// Shared types and helpers for the DMA read path tracker.
// Descriptor fields use maximum widths; the top narrows them.
package drc_pkg;

  localparam int PAGE_W      = 12;
  localparam int DESC_PATH_W = 4;
  localparam int DESC_ADDR_W = 64;

  typedef struct packed {
    logic [DESC_PATH_W-1:0] path;
    logic [DESC_ADDR_W-1:0] addr;
    logic [7:0]             len;
  } burst_t;

  function automatic int path_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [15:0] dwen_bytes(
    input logic [63:0] dwen
  );
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 64; i++)
      b = b + {13'd0, dwen[i], 2'b00};
    return b;
  endfunction

endpackage

// File: rtl/dma_read_path_tracker_if.sv
// Allocation, packer-beat and burst-descriptor bundle
// between splitter/packer, tracker and pusher.
interface dma_read_path_tracker_if #(
  parameter int P_PATHS      = 4,
  parameter int P_DATA_BYTES = 16,
  parameter int P_TAG_W      = 8,
  parameter int P_ADDR_W     = 32,
  parameter int P_LEN_W      = 13
);
  import drc_pkg::*;

  localparam int PW     = path_w(P_PATHS);
  localparam int P_DWEN = P_DATA_BYTES / 4;

  logic                alloc_valid;
  logic                alloc_ready;
  logic [P_TAG_W-1:0]  alloc_tag;
  logic [P_ADDR_W-1:0] alloc_dev_addr;
  logic [P_LEN_W-1:0]  alloc_len;
  logic [PW-1:0]       alloc_path;
  logic [P_PATHS-1:0]  path_credit_ok;
  logic [P_PATHS-1:0]  path_busy;
  logic                pkt_valid;
  logic                pkt_ready;
  logic [P_TAG_W-1:0]  pkt_tag;
  logic [P_DWEN-1:0]   pkt_dwen;
  logic [P_PATHS-1:0]  pkt_path_hit;
  logic                burst_valid;
  logic                burst_ready;
  logic [PW-1:0]       burst_path;
  logic [P_ADDR_W-1:0] burst_addr;
  logic [7:0]          burst_len;
  logic                err_unmatched;
  logic                err_overrun;

  modport master (
    output alloc_valid, alloc_tag,
    output alloc_dev_addr, alloc_len,
    output path_credit_ok,
    output pkt_valid, pkt_tag, pkt_dwen,
    output burst_ready,
    input  alloc_ready, alloc_path,
    input  path_busy, pkt_ready,
    input  pkt_path_hit, burst_valid,
    input  burst_path, burst_addr, burst_len,
    input  err_unmatched, err_overrun
  );

  modport slave (
    input  alloc_valid, alloc_tag,
    input  alloc_dev_addr, alloc_len,
    input  path_credit_ok,
    input  pkt_valid, pkt_tag, pkt_dwen,
    input  burst_ready,
    output alloc_ready, alloc_path,
    output path_busy, pkt_ready,
    output pkt_path_hit, burst_valid,
    output burst_path, burst_addr, burst_len,
    output err_unmatched, err_overrun
  );

endinterface

// File: rtl/drc_burst_queue.sv
// First-word-fall-through FIFO of burst descriptors.
// Push while full is accepted when a pop happens the same edge.
module drc_burst_queue
  import drc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   push,
  input  burst_t din,
  input  logic   pop,
  output burst_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  burst_t       mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dma_read_path_tracker.sv
// N-path read completion tracker: round-robin path allocation,
// tag steering of packer beats and burst descriptor generation.
module dma_read_path_tracker
  import drc_pkg::*;
#(
  parameter int P_PATHS      = 4,
  parameter int P_DATA_BYTES = 16,
  parameter int P_TAG_W      = 8,
  parameter int P_ADDR_W     = 32,
  parameter int P_LEN_W      = 13,
  parameter int P_MAX_BURST  = 16,
  parameter int P_BQ_DEPTH   = 4
) (
  input logic                   i_clk,
  input logic                   i_rst,
  dma_read_path_tracker_if.slave bus
);

  localparam int PW    = path_w(P_PATHS);
  localparam int CNT_W = $clog2(P_MAX_BURST + 1);

  logic [P_PATHS-1:0]  busy;
  logic [P_TAG_W-1:0]  tag_a   [P_PATHS];
  logic [P_LEN_W-1:0]  rem_a   [P_PATHS];
  logic [P_ADDR_W-1:0] start_a [P_PATHS];
  logic [P_ADDR_W-1:0] nxt_a   [P_PATHS];
  logic [CNT_W-1:0]    cnt_a   [P_PATHS];

  logic [P_PATHS-1:0]  match;
  logic [P_PATHS-1:0]  clash;
  logic [PW-1:0]       hit_idx;
  logic                any_match;
  logic [P_LEN_W-1:0]  bytes;
  logic [P_LEN_W-1:0]  new_rem;
  logic [P_ADDR_W-1:0] new_nxt;
  logic [CNT_W-1:0]    new_cnt;
  logic                overrun;
  logic                closes;
  logic                accept;
  logic                hit;
  logic                push;
  logic                pop;
  logic                q_full;
  logic                q_empty;
  burst_t              desc;
  burst_t              head;
  logic                found;
  logic [PW-1:0]       pick;
  logic [PW-1:0]       rr;
  logic                alloc_ok;
  int                  j;

  always_comb begin
    match = '0;
    clash = '0;
    for (int i = 0; i < P_PATHS; i++) begin
      match[i] = busy[i] && (tag_a[i] == bus.pkt_tag);
      clash[i] = busy[i] && (tag_a[i] == bus.alloc_tag);
    end
  end

  // Busy tags are unique, so at most one path matches.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < P_PATHS; i++)
      if (match[i])
        hit_idx = PW'(i);
  end

  assign any_match = |match;
  assign bytes   = P_LEN_W'(dwen_bytes(64'(bus.pkt_dwen)));
  assign overrun = bytes > rem_a[hit_idx];
  assign new_rem = rem_a[hit_idx] - bytes;
  assign new_nxt = nxt_a[hit_idx] + P_ADDR_W'(bytes);
  assign new_cnt = cnt_a[hit_idx] + CNT_W'(1);

  assign closes = any_match && !overrun && (
      !(&bus.pkt_dwen)
    || (new_cnt == CNT_W'(P_MAX_BURST))
    || (new_nxt[PAGE_W-1:0] == '0)
    || (new_rem == '0));

  assign bus.pkt_ready    = !q_full || !closes;
  assign accept           = bus.pkt_valid && bus.pkt_ready;
  assign hit              = accept && any_match && !overrun;
  assign bus.pkt_path_hit = hit ? match : '0;
  assign push             = hit && closes;

  always_comb begin
    desc      = '0;
    desc.path = DESC_PATH_W'(hit_idx);
    desc.addr = DESC_ADDR_W'(start_a[hit_idx]);
    desc.len  = 8'(cnt_a[hit_idx]);
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < P_PATHS; k++) begin
      j = int'(rr) + k;
      if (j >= P_PATHS)
        j = j - P_PATHS;
      if (!found && !busy[PW'(j)]
          && bus.path_credit_ok[PW'(j)]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  assign alloc_ok       = bus.alloc_valid && found && !(|clash);
  assign bus.alloc_ready = alloc_ok;
  assign bus.alloc_path  = pick;
  assign bus.path_busy   = busy;

  for (genvar g = 0; g < P_PATHS; g++) begin : g_path
    logic                busy_q;
    logic [P_TAG_W-1:0]  tag_q;
    logic [P_LEN_W-1:0]  rem_q;
    logic [P_ADDR_W-1:0] start_q;
    logic [P_ADDR_W-1:0] nxt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                take;
    logic                upd;

    assign take = alloc_ok && (pick == PW'(g));
    assign upd  = hit && (hit_idx == PW'(g));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        busy_q  <= 1'b0;
        tag_q   <= '0;
        rem_q   <= '0;
        start_q <= '0;
        nxt_q   <= '0;
        cnt_q   <= '0;
      end else if (take) begin
        busy_q  <= 1'b1;
        tag_q   <= bus.alloc_tag;
        rem_q   <= bus.alloc_len;
        start_q <= bus.alloc_dev_addr;
        nxt_q   <= bus.alloc_dev_addr;
        cnt_q   <= '0;
      end else if (upd) begin
        rem_q <= new_rem;
        nxt_q <= new_nxt;
        if (closes) begin
          start_q <= new_nxt;
          cnt_q   <= '0;
          busy_q  <= new_rem != '0;
        end else begin
          cnt_q <= new_cnt;
        end
      end
    end

    assign busy[g]    = busy_q;
    assign tag_a[g]   = tag_q;
    assign rem_a[g]   = rem_q;
    assign start_a[g] = start_q;
    assign nxt_a[g]   = nxt_q;
    assign cnt_a[g]   = cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr                <= '0;
      bus.err_unmatched <= 1'b0;
      bus.err_overrun   <= 1'b0;
    end else begin
      if (alloc_ok)
        rr <= (pick == PW'(P_PATHS - 1))
            ? '0 : pick + PW'(1);
      bus.err_unmatched <= accept && !any_match;
      bus.err_overrun   <= accept && any_match && overrun;
    end
  end

  drc_burst_queue #(
    .DEPTH (P_BQ_DEPTH)
  ) u_bq (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .din   (desc),
    .pop   (pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign pop             = !q_empty && bus.burst_ready;
  assign bus.burst_valid = !q_empty;
  assign bus.burst_path  = q_empty ? '0 : PW'(head.path);
  assign bus.burst_addr  = q_empty ? '0 : P_ADDR_W'(head.addr);
  assign bus.burst_len   = q_empty ? '0 : head.len;

endmodule

// File: tb/tb_dma_read_path_tracker.sv
// Directed bench for the read path tracker with
// a 4-beat max burst and a 4-entry descriptor queue.
module tb_dma_read_path_tracker;

  localparam int NP = 4;
  localparam int DB = 16;
  localparam int TW = 8;
  localparam int AW = 32;
  localparam int LW = 13;
  localparam int MB = 4;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dma_read_path_tracker_if #(
    .P_PATHS(NP), .P_DATA_BYTES(DB), .P_TAG_W(TW),
    .P_ADDR_W(AW), .P_LEN_W(LW)
  ) bus ();

  dma_read_path_tracker #(
    .P_PATHS(NP), .P_DATA_BYTES(DB), .P_TAG_W(TW),
    .P_ADDR_W(AW), .P_LEN_W(LW),
    .P_MAX_BURST(MB), .P_BQ_DEPTH(QD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input string tag,
                       input logic [7:0]  t,
                       input logic [31:0] a,
                       input logic [12:0] l,
                       input logic        exp_rdy,
                       input logic [1:0]  exp_path);
    bus.alloc_valid    = 1'b1;
    bus.alloc_tag      = t;
    bus.alloc_dev_addr = a;
    bus.alloc_len      = l;
    @(negedge clk);
    check({tag, ".ready"}, bus.alloc_ready, exp_rdy);
    if (exp_rdy)
      check({tag, ".path"}, bus.alloc_path, exp_path);
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic beat(input string tag,
                      input logic [7:0] t,
                      input logic [3:0] dwen,
                      input logic       exp_rdy,
                      input logic [3:0] exp_hit);
    bus.pkt_valid = 1'b1;
    bus.pkt_tag   = t;
    bus.pkt_dwen  = dwen;
    @(negedge clk);
    check({tag, ".ready"}, bus.pkt_ready, exp_rdy);
    check({tag, ".hit"}, bus.pkt_path_hit, exp_hit);
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic pop(input string tag,
                     input logic [1:0]  p,
                     input logic [31:0] a,
                     input logic [7:0]  l);
    check({tag, ".valid"}, bus.burst_valid, 1'b1);
    check({tag, ".path"}, bus.burst_path, p);
    check({tag, ".addr"}, bus.burst_addr, a);
    check({tag, ".len"}, bus.burst_len, l);
    bus.burst_ready = 1'b1;
    tick();
    bus.burst_ready = 1'b0;
  endtask

  initial begin
    bus.alloc_valid    = 1'b0;
    bus.alloc_tag      = '0;
    bus.alloc_dev_addr = '0;
    bus.alloc_len      = '0;
    bus.path_credit_ok = 4'hF;
    bus.pkt_valid      = 1'b0;
    bus.pkt_tag        = '0;
    bus.pkt_dwen       = '0;
    bus.burst_ready    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.alloc_ready", bus.alloc_ready, 1'b0);
    check("rst.busy", bus.path_busy, 4'h0);
    check("rst.bvalid", bus.burst_valid, 1'b0);
    check("rst.baddr", bus.burst_addr, 32'h0);
    check("rst.blen", bus.burst_len, 8'h0);
    check("rst.unm", bus.err_unmatched, 1'b0);
    check("rst.ovr", bus.err_overrun, 1'b0);
    check("rst.hit", bus.pkt_path_hit, 4'h0);
    rst = 1'b0;
    tick();

    // single request, four full beats, one burst
    alloc("t1.alloc", 8'd5, 32'h1000, 13'd64, 1'b1, 2'd0);
    check("t1.busy", bus.path_busy, 4'b0001);
    for (int i = 0; i < 4; i++)
      beat("t1.beat", 8'd5, 4'hF, 1'b1, 4'b0001);
    check("t1.busy_clr", bus.path_busy, 4'b0000);
    pop("t1.burst", 2'd0, 32'h1000, 8'd3);
    check("t1.qempty", bus.burst_valid, 1'b0);

    rst = 1'b1;
    tick();
    check("rst2.busy", bus.path_busy, 4'h0);
    rst = 1'b0;
    tick();

    // round-robin restarts at path 0 after reset
    alloc("t2.a0", 8'd1, 32'h0FF0, 13'd48, 1'b1, 2'd0);
    alloc("t2.a1", 8'd2, 32'h2000, 13'd96, 1'b1, 2'd1);
    alloc("t2.a2", 8'd3, 32'h3000, 13'd8, 1'b1, 2'd2);
    alloc("t2.clash", 8'd2, 32'h5000, 13'd16, 1'b0, 2'd0);
    bus.path_credit_ok = 4'b0111;
    alloc("t2.nocred", 8'd7, 32'h4000, 13'd64, 1'b0, 2'd0);
    bus.path_credit_ok = 4'hF;
    alloc("t2.a3", 8'd7, 32'h4000, 13'd64, 1'b1, 2'd3);
    check("t2.busy", bus.path_busy, 4'hF);

    // 4 KB crossing
    for (int i = 0; i < 3; i++)
      beat("t3.beat", 8'd1, 4'hF, 1'b1, 4'b0001);
    check("t3.busy", bus.path_busy, 4'b1110);
    pop("t3.b0", 2'd0, 32'h0FF0, 8'd0);
    pop("t3.b1", 2'd0, 32'h1000, 8'd1);

    // max-burst split
    for (int i = 0; i < 6; i++)
      beat("t4.beat", 8'd2, 4'hF, 1'b1, 4'b0010);
    pop("t4.b0", 2'd1, 32'h2000, 8'd3);
    pop("t4.b1", 2'd1, 32'h2040, 8'd1);
    check("t4.busy", bus.path_busy, 4'b1100);

    // overrun: 16 bytes against 8 remaining
    beat("t5.ovr", 8'd3, 4'hF, 1'b1, 4'b0000);
    check("t5.err_ovr", bus.err_overrun, 1'b1);
    check("t5.err_unm", bus.err_unmatched, 1'b0);
    check("t5.busy", bus.path_busy, 4'b1100);
    tick();
    check("t5.ovr_pulse", bus.err_overrun, 1'b0);
    beat("t5.fit", 8'd3, 4'b0011, 1'b1, 4'b0100);
    pop("t5.b0", 2'd2, 32'h3000, 8'd0);
    check("t5.busy_clr", bus.path_busy, 4'b1000);

    // unmatched tag
    beat("t6.unm", 8'd9, 4'hF, 1'b1, 4'b0000);
    check("t6.err_unm", bus.err_unmatched, 1'b1);
    check("t6.err_ovr", bus.err_overrun, 1'b0);
    tick();
    check("t6.unm_pulse", bus.err_unmatched, 1'b0);

    // fill the queue with partial-beat bursts
    for (int i = 0; i < 4; i++)
      beat("t7.fill", 8'd7, 4'b0001, 1'b1, 4'b1000);
    beat("t7.open", 8'd7, 4'hF, 1'b1, 4'b1000);
    bus.pkt_valid = 1'b1;
    bus.pkt_tag   = 8'd7;
    bus.pkt_dwen  = 4'b0001;
    @(negedge clk);
    check("t7.blk.ready", bus.pkt_ready, 1'b0);
    check("t7.blk.hit", bus.pkt_path_hit, 4'b0000);
    check("t7.head.addr", bus.burst_addr, 32'h4000);
    check("t7.head.len", bus.burst_len, 8'd0);
    bus.burst_ready = 1'b1;
    tick();
    bus.burst_ready = 1'b0;
    @(negedge clk);
    check("t7.rel.ready", bus.pkt_ready, 1'b1);
    check("t7.rel.hit", bus.pkt_path_hit, 4'b1000);
    tick();
    bus.pkt_valid = 1'b0;
    pop("t7.b1", 2'd3, 32'h4004, 8'd0);
    pop("t7.b2", 2'd3, 32'h4008, 8'd0);
    pop("t7.b3", 2'd3, 32'h400C, 8'd0);
    pop("t7.b4", 2'd3, 32'h4010, 8'd1);
    check("t7.qempty", bus.burst_valid, 1'b0);
    check("t7.busy", bus.path_busy, 4'b1000);

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
